weight_sram_ctrl: RTL and testbench

//  Single-port arbiter/sequencer in front of one weight SRAM (DW x DEPTH, 1-cycle registered read, we=1 write / we=0 read).

---
 rtl/wsc_pkg.sv | 12 +
 rtl/wsc_arbiter.sv | 58 +++++
 rtl/weight_sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_weight_sram_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wsc_pkg.sv
// Package for the weight SRAM controller.
//   state_t : burst sequencer states
//   gsel_t  : which requester owns the SRAM port this cycle
//   *_DEF   : default geometry (16-bit words, 12-bit address, 2000 words)
package wsc_pkg;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 12;
    localparam int DEPTH_DEF = 2000;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    typedef enum logic [1:0] {G_NONE, G_WR, G_RD} gsel_t;
endpackage

// File: rtl/wsc_arbiter.sv
// Two-requester grant logic for the single SRAM port.
// Ports:
//   clk, rst_n : clock, async active-low reset (used only by the round-robin flop)
//   wr_req     : host write pending
//   rd_req     : burst reader wants a read slot
//   gsel       : combinational grant select
// Macro WSC_RR_ARB_EN: when defined, alternate grants whenever both requesters
// are pending; otherwise the write always wins. A lone requester is always granted.
module wsc_arbiter
    import wsc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_req,
    input  logic  rd_req,
    output gsel_t gsel
);

`ifdef WSC_RR_ARB_EN
    // last_wr_q=1 means the write owned the most recent granted cycle.
    // Reset as "read last" so the write wins the first contention.
    logic last_wr_q, last_wr_d;

    always_comb begin
        gsel      = G_NONE;
        last_wr_d = last_wr_q;
        if (wr_req && rd_req)
            gsel = last_wr_q ? G_RD : G_WR;
        else if (wr_req)
            gsel = G_WR;
        else if (rd_req)
            gsel = G_RD;
        if (gsel == G_WR)
            last_wr_d = 1'b1;
        else if (gsel == G_RD)
            last_wr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_wr_q <= 1'b0;
        else
            last_wr_q <= last_wr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    always_comb begin
        gsel = G_NONE;
        if (wr_req)
            gsel = G_WR;
        else if (rd_req)
            gsel = G_RD;
    end
`endif

endmodule

// File: rtl/weight_sram_ctrl.sv
// Single-port sequencer/arbiter in front of one weight SRAM (1-cycle registered read).
// Shares the port between a host write stream and a sequential burst reader.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data : host write (wr_ready is the combinational grant)
//   rd_start/rd_base/rd_len         : burst request, sampled only while idle
//   rd_busy/rd_valid/rd_data/rd_done : burst status and returned words
//   err_oob                          : sticky flag for writes at addr >= DEPTH
//   sram_we/sram_addr/sram_d/sram_q  : SRAM port
// Macro WSC_RR_ARB_EN selects round-robin arbitration (see wsc_arbiter);
// default is write-priority.
module weight_sram_ctrl
    import wsc_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_len,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_done,
    output logic          err_oob,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          err_oob_q, err_oob_d;
    logic          wr_oob;
    gsel_t         gsel;

    assign wr_oob = wr_addr > LAST_ADDR;

    wsc_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_req (wr_valid),
        .rd_req (state_q == BURST),
        .gsel   (gsel)
    );

    // SRAM port mux. An out-of-range write is consumed (wr_ready) but
    // never reaches the array.
    always_comb begin
        wr_ready  = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_d    = '0;
        case (gsel)
            G_WR: begin
                wr_ready  = 1'b1;
                sram_we   = !wr_oob;
                sram_addr = wr_addr;
                sram_d    = wr_data;
            end
            G_RD: sram_addr = ptr_q;
            default: ;
        endcase
    end

    // Burst sequencer. rd_done is registered so it lines up with the
    // last rd_valid (the cycle after the final issue), or one cycle after
    // a zero-length start.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        rd_valid_d = (gsel == G_RD);
        err_oob_d  = err_oob_q | ((gsel == G_WR) && wr_oob);
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    if (rd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = BURST;
                        ptr_d   = rd_base;
                        rem_d   = rd_len;
                    end
                end
            end
            BURST: begin
                if (gsel == G_RD) begin
                    ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == AW'(1)) begin
                        state_d = DRAIN;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign rd_busy  = (state_q != IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = sram_q;
    assign rd_done  = done_q;
    assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: cycle-vector table for basic writes/bursts,
// hand sequences for arbitration, out-of-range write and mid-burst reset.
module tb_weight_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_start;
    logic [11:0] rd_base, rd_len;
    logic        rd_busy, rd_valid, rd_done, err_oob;
    logic [15:0] rd_data;
    logic        sram_we;
    logic [11:0] sram_addr;
    logic [15:0] sram_d, sram_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_sram_ctrl #(.DW(16), .AW(12), .DEPTH(2000)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .err_oob(err_oob),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural 16x2000 SRAM, registered read.
    logic [15:0] mem [2000];
    always @(posedge clk) begin
        if (sram_we && sram_addr < 12'd2000) mem[sram_addr] <= sram_d;
        sram_q <= (sram_addr < 12'd2000) ? mem[sram_addr] : 16'h0;
    end

    typedef struct {
        logic        wv;
        logic [11:0] wa;
        logic [15:0] wd;
        logic        rs;
        logic [11:0] rb, rl;
        logic        wrdy, we;
        logic [11:0] addr;
        logic        rv;
        logic [15:0] rdat;
        logic        done, busy;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic wv, logic [11:0] wa, logic [15:0] wd, logic rs,
                                logic [11:0] rb, logic [11:0] rl, logic wrdy, logic we,
                                logic [11:0] addr, logic rv, logic [15:0] rdat,
                                logic done, logic busy);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rs = rs; v.rb = rb; v.rl = rl;
        v.wrdy = wrdy; v.we = we; v.addr = addr; v.rv = rv; v.rdat = rdat;
        v.done = done; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock cycle: inputs driven just after the rising edge, caller
    // samples after the falling edge.
    task automatic cyc_in(input logic wv, input logic [11:0] wa, input logic [15:0] wd,
                          input logic rs, input logic [11:0] rb, input logic [11:0] rl);
        @(posedge clk);
        #1;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_start = rs; rd_base = rb; rd_len = rl;
        @(negedge clk);
    endtask

    task automatic idle_cyc;
        cyc_in(1'b0, 12'd0, 16'd0, 1'b0, 12'd0, 12'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] wrr, wrv, wdn;
        logic [12:0] exp_wrr, exp_wrv;
        logic [15:0] words[$];
        int wcount, nrv, ndone;

        // --- cycle vector table ---
        // test 1: preload 5..9, burst base 5 len 5
        for (int i = 0; i < 5; i++)
            vecs[i] = mk(1'b1, 12'(5 + i), 16'(16'hA0 + i), 1'b0, 12'd0, 12'd0,
                         1'b1, 1'b1, 12'(5 + i), 1'b0, 16'h0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 12'd0, 16'h0, 1'b1, 12'd5, 12'd5, 1'b0, 1'b0, 12'd0, 1'b0, 16'h0,  1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd5, 1'b0, 16'h0,  1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd6, 1'b1, 16'hA0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd7, 1'b1, 16'hA1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd8, 1'b1, 16'hA2, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd9, 1'b1, 16'hA3, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b1, 16'hA4, 1'b1, 1'b1);
        vecs[12] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 16'h0,  1'b0, 1'b0);
        // test 2: wrap 1998,1999,0,1
        vecs[13] = mk(1'b1, 12'd1998, 16'hB0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd1998, 1'b0, 16'h0, 1'b0, 1'b0);
        vecs[14] = mk(1'b1, 12'd1999, 16'hB1, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd1999, 1'b0, 16'h0, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 12'd0,    16'hB2, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd0,    1'b0, 16'h0, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 12'd1,    16'hB3, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd1,    1'b0, 16'h0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 12'd0, 16'h0, 1'b1, 12'd1998, 12'd4, 1'b0, 1'b0, 12'd0,    1'b0, 16'h0,  1'b0, 1'b0);
        vecs[18] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd1998, 1'b0, 16'h0,  1'b0, 1'b1);
        vecs[19] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd1999, 1'b1, 16'hB0, 1'b0, 1'b1);
        vecs[20] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd0,    1'b1, 16'hB1, 1'b0, 1'b1);
        vecs[21] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd1,    1'b1, 16'hB2, 1'b0, 1'b1);
        vecs[22] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd0,    1'b1, 16'hB3, 1'b1, 1'b1);
        vecs[23] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0,    1'b0, 1'b0, 12'd0,    1'b0, 16'h0,  1'b0, 1'b0);
        // test 3: zero-length burst
        vecs[24] = mk(1'b0, 12'd0, 16'h0, 1'b1, 12'd7, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        vecs[25] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 16'h0, 1'b1, 1'b0);
        vecs[26] = mk(1'b0, 12'd0, 16'h0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 16'h0, 1'b0, 1'b0);

        // --- reset state ---
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0;
        repeat (2) @(negedge clk);
        chk("reset", {rd_busy, rd_valid, rd_done, err_oob, sram_we, wr_ready, sram_addr, sram_d},
            64'h0);
        rst_n = 1'b1;

        // --- table ---
        for (int i = 0; i < 27; i++) begin
            cyc_in(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].rb, vecs[i].rl);
            chk($sformatf("vec%0d", i),
                {wr_ready, sram_we, sram_addr, rd_valid, rd_done, rd_busy, err_oob,
                 (rd_valid ? rd_data : 16'h0)},
                {vecs[i].wrdy, vecs[i].we, vecs[i].addr, vecs[i].rv, vecs[i].done, vecs[i].busy,
                 1'b0, (vecs[i].rv ? vecs[i].rdat : 16'h0)});
        end

        // --- test 4: writes contend with a len=8 burst ---
        for (int i = 0; i < 8; i++)
            cyc_in(1'b1, 12'(100 + i), 16'(16'hC0 + i), 1'b0, 12'd0, 12'd0);
        cyc_in(1'b0, 12'd0, 16'h0, 1'b1, 12'd100, 12'd8);
        wcount = 0; wrr = '0; wrv = '0; wdn = '0; words.delete();
        for (int i = 0; i < 13; i++) begin
            cyc_in(1'(i >= 2 && wcount < 3), 12'(200 + wcount), 16'(16'hD0 + wcount),
                   1'b0, 12'd0, 12'd0);
            wrr[i] = wr_ready;
            wrv[i] = rd_valid;
            wdn[i] = rd_done;
            if (rd_valid) words.push_back(rd_data);
            if (wr_ready) wcount++;
        end
`ifdef WSC_RR_ARB_EN
        exp_wrr = 13'h0054;
        exp_wrv = 13'h0F56;
`else
        exp_wrr = 13'h001C;
        exp_wrv = 13'h0FC6;
`endif
        chk("t4 wr_ready pattern", 64'(wrr), 64'(exp_wrr));
        chk("t4 rd_valid pattern", 64'(wrv), 64'(exp_wrv));
        chk("t4 rd_done pattern", 64'(wdn), 64'h0800);
        chk("t4 word count", 64'(words.size()), 64'd8);
        for (int i = 0; i < 8 && i < words.size(); i++)
            chk($sformatf("t4 word%0d", i), 64'(words[i]), 64'(16'hC0 + i));
        chk("t4 busy end", 64'(rd_busy), 64'd0);
        chk("t4 write mem", {16'h0, mem[200], mem[201], mem[202]}, 64'h0000_00D0_00D1_00D2);

        // --- test 5: out-of-range write ---
        cyc_in(1'b1, 12'd2000, 16'hFFFF, 1'b0, 12'd0, 12'd0);
        chk("t5 oob grant", {wr_ready, sram_we, err_oob}, 64'b100);
        idle_cyc();
        chk("t5 err set", 64'(err_oob), 64'd1);
        repeat (3) idle_cyc();
        chk("t5 err sticky", 64'(err_oob), 64'd1);
        cyc_in(1'b0, 12'd0, 16'h0, 1'b1, 12'd0, 12'd1);
        idle_cyc();
        idle_cyc();
        chk("t5 read 0", {rd_valid, rd_done, rd_data}, {1'b1, 1'b1, 16'hB2});

        // --- test 6: reset during cycle 3 of a len=10 burst ---
        cyc_in(1'b0, 12'd0, 16'h0, 1'b1, 12'd100, 12'd10);
        idle_cyc();
        idle_cyc();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async reset",
            {rd_busy, rd_valid, rd_done, err_oob, sram_we, wr_ready, sram_addr, sram_d}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 5; i++) begin
            idle_cyc();
            nrv += int'(rd_valid) + int'(rd_busy);
        end
        chk("t6 quiet after reset", 64'(nrv), 64'd0);
        cyc_in(1'b0, 12'd0, 16'h0, 1'b1, 12'd100, 12'd3);
        words.delete();
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            idle_cyc();
            if (rd_valid) words.push_back(rd_data);
            if (rd_done) ndone++;
        end
        chk("t6 post count", 64'(words.size()), 64'd3);
        for (int i = 0; i < 3 && i < words.size(); i++)
            chk($sformatf("t6 word%0d", i), 64'(words[i]), 64'(16'hC0 + i));
        chk("t6 done", 64'(ndone), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
